led_counter_ctrl: RTL and testbench

//   Parametrised LED step counter: prescaler with run-time speed select, pause enable,

---
 rtl/ledcnt_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 62 ++++++
 rtl/led_counter_ctrl.sv | 110 +++++++++++
 tb/tb_led_counter_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledcnt_pkg.sv
// Shared definitions for the LED step counter: counting-mode encodings,
// debouncer level states and the prescaler width helper.
package ledcnt_pkg;

    // Counting mode as seen on the mode input
    typedef enum logic {
        MODE_WRAP   = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_e;

    // Debounced button level
    typedef enum logic {
        BTN_RELEASED = 1'b0,
        BTN_PRESSED  = 1'b1
    } btn_state_e;

    // Bits needed to hold every prescaler count up to the slowest period
    // (BASE_DIV << (NUM_SPEEDS-1)) - 1; never returns less than 1.
    function automatic int presc_width(input longint base_div, input int num_speeds);
        longint top;
        int     w;
        top = base_div << (num_speeds - 1);
        w   = 1;
        while ((longint'(1) << w) < top) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter that
// accepts a new level only after DEB_CYCLES identical samples, and a
// one-cycle pulse on every accepted released->pressed transition.
module btn_debounce
    import ledcnt_pkg::*;
#(
    parameter int DEB_CYCLES = 2**20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync_a;
    logic          sync_b;
    btn_state_e    sample;
    btn_state_e    state;
    logic [CW-1:0] stable_cnt;

    // Synchronised raw level expressed as a button state
    always_comb begin
        sample = sync_b ? BTN_PRESSED : BTN_RELEASED;
    end

    // Bring the asynchronous button into the clock domain
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Accept a new level after DEB_CYCLES consecutive differing samples; pulse on press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BTN_RELEASED;
            stable_cnt  <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sample != state) begin
                if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
                    state       <= sample;
                    stable_cnt  <= '0;
                    press_pulse <= (sample == BTN_PRESSED);
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_counter_ctrl.sv
// LED step counter: prescaler with run-time speed select and pause, debounced
// direction-toggle button, wrap or bounce counting.
// Optional feature: define LEDCNT_LOAD_EN to add the load / load_val ports
// (synchronous parallel load that also restarts the prescaler).
module led_counter_ctrl
    import ledcnt_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int NUM_SPEEDS = 4,
    parameter  int BASE_DIV   = 2**22,
    parameter  int DEB_CYCLES = 2**20,
    localparam int SW_W       = $clog2(NUM_SPEEDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SW_W-1:0]  SW,
    input  logic             En,
    input  logic             UD,
    input  logic             mode,
`ifdef LEDCNT_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] LED,
    output logic             dir_up,
    output logic             step
);

    localparam int               PW      = presc_width(BASE_DIV, NUM_SPEEDS);
    localparam logic [WIDTH-1:0] LED_MAX = '1;

    logic [PW-1:0]    presc;
    logic [PW-1:0]    term;
    logic [SW_W-1:0]  sw_q;
    logic             sched;
    logic             tg;
    logic             dir_eff;
    logic             load_now;
    logic [WIDTH-1:0] load_value;

`ifdef LEDCNT_LOAD_EN
    assign load_now   = load;
    assign load_value = load_val;
`else
    assign load_now   = 1'b0;
    assign load_value = '0;
`endif

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (UD),
        .press_pulse (tg)
    );

    // Terminal count for the selected speed and the toggled direction
    always_comb begin
        term    = (PW'(BASE_DIV) << SW) - PW'(1);
        dir_eff = dir_up ^ tg;
    end

    // Prescaler: frozen while paused, restarted by a speed change or a load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            sw_q  <= '0;
            sched <= 1'b0;
        end else begin
            sw_q <= SW;
            if (load_now || (SW != sw_q)) begin
                presc <= '0;
                sched <= 1'b0;
            end else if (En) begin
                // A pending step is always consumed in this same cycle when En=1,
                // so sched simply mirrors the terminal count.
                sched <= (presc == term);
                presc <= (presc == term) ? '0 : presc + 1'b1;
            end
        end
    end

    // Counter and direction: apply toggle every cycle, step on a scheduled step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            LED    <= '0;
            dir_up <= 1'b1;
            step   <= 1'b0;
        end else begin
            step   <= 1'b0;
            dir_up <= dir_eff;
            if (load_now) begin
                LED <= load_value;
            end else if (sched && En) begin
                step <= 1'b1;
                if (mode == MODE_BOUNCE && dir_eff && LED == LED_MAX) begin
                    LED    <= LED_MAX - 1'b1;
                    dir_up <= 1'b0;
                end else if (mode == MODE_BOUNCE && !dir_eff && LED == '0) begin
                    LED    <= WIDTH'(1);
                    dir_up <= 1'b1;
                end else begin
                    LED <= dir_eff ? LED + 1'b1 : LED - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Self-checking bench for led_counter_ctrl (WIDTH=4, NUM_SPEEDS=4, BASE_DIV=4,
// DEB_CYCLES=3). Every step pulse pops one expected {LED, dir_up} record.
module tb_led_counter_ctrl;

    localparam int WIDTH      = 4;
    localparam int NUM_SPEEDS = 4;
    localparam int BASE_DIV   = 4;
    localparam int DEB_CYCLES = 3;

    logic       clk;
    logic       reset;
    logic [1:0] sw;
    logic       en;
    logic       ud;
    logic       mode;
    logic [3:0] led;
    logic       dir_up;
    logic       step;
`ifdef LEDCNT_LOAD_EN
    logic       load;
    logic [3:0] load_val;
`endif

    led_counter_ctrl #(
        .WIDTH      (WIDTH),
        .NUM_SPEEDS (NUM_SPEEDS),
        .BASE_DIV   (BASE_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .SW       (sw),
        .En       (en),
        .UD       (ud),
        .mode     (mode),
`ifdef LEDCNT_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .LED      (led),
        .dir_up   (dir_up),
        .step     (step)
    );

    typedef struct packed {
        logic [3:0] led;
        logic       dir;
    } exp_t;

    typedef struct {
        logic [1:0] sw;
        logic       en;
        logic       mode;
        logic [3:0] led;
        logic       dir;
        int         gap;   // expected clocks since previous step, 0 = not checked
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    int total         = 0;
    int bad           = 0;
    int cyc           = 0;
    int step_seen     = 0;
    int last_step_cyc = 0;
    int prev_cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Scoreboard: each step pulse consumes one expected record
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (step === 1'b1) begin
            step_seen++;
            last_step_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_step: step=1 with LED=%0d, required no step", led);
            end else begin
                e = exp_q.pop_front();
                check("sb_led", led, e.led);
                check("sb_dir", dir_up, e.dir);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [3:0] l, input logic d);
        exp_q.push_back('{l, d});
    endtask

    task automatic wait_steps(input int n, input string name);
        int target;
        int budget;
        target = step_seen + n;
        budget = 20 * n + 20;
        while (step_seen < target && budget > 0) begin
            tick();
            budget--;
        end
        if (step_seen < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: saw %0d steps, required %0d", name, n - (target - step_seen), n);
            exp_q.delete();
        end
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            sw   = vecs[i].sw;
            en   = vecs[i].en;
            mode = vecs[i].mode;
            push(vecs[i].led, vecs[i].dir);
            wait_steps(1, $sformatf("vec%0d", i));
            if (vecs[i].gap != 0)
                check($sformatf("vec%0d_gap", i), last_step_cyc - prev_cyc, vecs[i].gap);
            prev_cyc = last_step_cyc;
        end
    endtask

    task automatic wait_dir(input logic want, input int limit);
        int k;
        k = 0;
        while (dir_up !== want && k < limit) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int   mark;
        int   s0;
        int   lat;
        int   flips;
        logic prev_dir;

        // Wrap up from reset: first step 5 clk after release, then every 4
        for (int i = 1; i <= 16; i++)
            vecs.push_back('{2'd0, 1'b1, 1'b0, 4'(i), 1'b1, (i == 1) ? 5 : 4});
        // Speed 2: change clears prescaler (1) + 16-cycle period + step register (1)
        vecs.push_back('{2'd2, 1'b1, 1'b0, 4'd1, 1'b1, 18});
        vecs.push_back('{2'd2, 1'b1, 1'b0, 4'd2, 1'b1, 16});
        // Bounce from LED=4 going down (indices 18..)
        for (int v = 3; v >= 0; v--)  vecs.push_back('{2'd0, 1'b1, 1'b1, 4'(v), 1'b0, 4});
        vecs.push_back('{2'd0, 1'b1, 1'b1, 4'd1, 1'b1, 4});
        for (int v = 2; v <= 15; v++) vecs.push_back('{2'd0, 1'b1, 1'b1, 4'(v), 1'b1, 4});
        for (int v = 14; v >= 0; v--) vecs.push_back('{2'd0, 1'b1, 1'b1, 4'(v), 1'b0, 4});
        vecs.push_back('{2'd0, 1'b1, 1'b1, 4'd1, 1'b1, 4});

        reset = 1'b1;
        sw    = 2'd0;
        en    = 1'b0;
        ud    = 1'b0;
        mode  = 1'b0;
`ifdef LEDCNT_LOAD_EN
        load     = 1'b0;
        load_val = 4'd0;
`endif
        tick();
        tick();
        check("rst_led", led, 0);
        check("rst_dir", dir_up, 1);
        check("rst_step", step, 0);

        reset    = 1'b0;
        prev_cyc = cyc;
        apply_vecs(0, 17);

        // Speed 2 -> 0 mid-period: compare+clear (1) + 4-cycle period + step register (1)
        repeat (6) tick();
        sw   = 2'd0;
        mark = cyc;
        push(4'd3, 1'b1);
        wait_steps(1, "sw_change");
        check("sw_change_latency", last_step_cyc - mark, 6);

        // Pause for 10 clk: LED and prescaler phase frozen, step 10 clk late
        mark = last_step_cyc;
        tick();
        en = 1'b0;
        s0 = step_seen;
        repeat (10) tick();
        check("pause_led_hold", led, 3);
        check("pause_no_step", step_seen, s0);
        en = 1'b1;
        push(4'd4, 1'b1);
        wait_steps(1, "pause");
        check("pause_phase_kept", last_step_cyc - mark, 14);

        // Bouncy press while paused: exactly one toggle, within 6 clk of steady level
        en = 1'b0;
        ud = 1'b1; tick();
        ud = 1'b0; tick();
        ud = 1'b1;
        lat      = 0;
        flips    = 0;
        prev_dir = dir_up;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (dir_up !== prev_dir) flips++;
            prev_dir = dir_up;
            if (lat == 0 && dir_up === 1'b0) lat = k;
        end
        check("tg_single_toggle", flips, 1);
        check("tg_latency_within_6", (lat >= 1 && lat <= 6), 1);
        check("tg_dir_down", dir_up, 0);
        ud = 1'b0;
        repeat (12) tick();
        check("release_no_toggle", dir_up, 0);
        check("paused_led_hold", led, 4);

        en = 1'b1;
        push(4'd3, 1'b0); push(4'd2, 1'b0); push(4'd1, 1'b0); push(4'd0, 1'b0); push(4'd15, 1'b0);
        wait_steps(5, "down_wrap");

        // Second press while paused turns direction back up
        en = 1'b0;
        ud = 1'b1;
        wait_dir(1'b1, 12);
        check("tg2_dir_up", dir_up, 1);
        ud = 1'b0;
        repeat (12) tick();
        en = 1'b1;
        for (int v = 0; v <= 4; v++) push(4'(v), 1'b1);
        wait_steps(5, "up_wrap");

        // Press timed so the toggle pulse coincides with the step leaving LED=5
        tick();
        tick();
        ud = 1'b1;
        push(4'd5, 1'b1);
        push(4'd4, 1'b0);
        wait_steps(2, "tg_with_step");
        check("tg_step_dir", dir_up, 0);

        // Switch to bounce mid-run
        ud       = 1'b0;
        prev_cyc = last_step_cyc;
        apply_vecs(18, vecs.size() - 1);
        en = 1'b0;

`ifdef LEDCNT_LOAD_EN
        // Load coincident with a scheduled step: load wins, step suppressed
        en = 1'b1;
        push(4'd2, 1'b1);
        wait_steps(1, "pre_load");
        repeat (3) tick();
        load     = 1'b1;
        load_val = 4'd9;
        s0       = step_seen;
        tick();
        mark = cyc;
        check("load_led", led, 9);
        check("load_step_suppressed", step, 0);
        check("load_no_step_seen", step_seen, s0);
        load = 1'b0;
        push(4'd10, 1'b1);
        wait_steps(1, "post_load");
        check("load_clears_presc", last_step_cyc - mark, 5);
        en = 1'b0;
`endif

        // Async reset mid-debounce and mid-period
        ud = 1'b1;
        wait_dir(1'b0, 12);
        check("pre_reset_dir_down", dir_up, 0);
        ud = 1'b0;
        tick();
        tick();
        #3 reset = 1'b1;
        #1;
        check("async_rst_led", led, 0);
        check("async_rst_dir", dir_up, 1);
        check("async_rst_step", step, 0);
        tick();
        tick();
        reset = 1'b0;
        en    = 1'b1;
        mark  = cyc;
        push(4'd1, 1'b1);
        wait_steps(1, "post_reset");
        check("post_rst_first_step", last_step_cyc - mark, 5);
        en = 1'b0;
        tick();
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
